// File: rtl/updown_move_ctrl.sv
// ---------------------------------------------------------------------------
// updown_move_ctrl
//
// Move controller for a 4-bit wrapping up/down counter. It accepts a "move to
// target" command over a valid/ready handshake and picks the shorter
// wrap-around direction once, on the first evaluation. It then steps the
// counter one position at a time, waiting a programmable dwell before each
// step. A command finishes when the counter reaches the target, when it is
// aborted, or when 8 steps have not reached the target (timeout). Each
// finish raises a one-cycle done pulse together with a status code.
//
// Ports
//   clk         in   rising-edge clock
//   arst        in   asynchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  controller idle and able to accept a command
//   cmd_target  in   [3:0] target counter value, latched on handshake
//   cmd_dwell   in   [DWELL_W-1:0] idle cycles before each step, latched
//   abort       in   cancel the active command (ignored while idle)
//   cnt_q       in   [3:0] current counter value fed back from the counter
//   cnt_en      out  counter step enable, one cycle per step
//   cnt_dir     out  step direction, 1 = up, 0 = down
//   busy        out  a command is in progress
//   done        out  one-cycle completion pulse
//   status      out  [1:0] 00 reached, 01 aborted, 10 timeout; held until
//                    the next done
// ---------------------------------------------------------------------------
module updown_move_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_target,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    input  logic [3:0]         cnt_q,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StWait,
        StStep
    } state_e;

    localparam logic [1:0] StatReached = 2'b00;
    localparam logic [1:0] StatAborted = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;

    // A command may issue at most this many steps before it times out.
    localparam logic [3:0] MaxSteps = 4'd8;

    state_e               state_q, state_d;
    logic [3:0]           target_q, target_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
    logic [3:0]           step_q, step_d;
    logic                 first_q, first_d;
    logic                 dir_q, dir_d;
    logic                 done_q, done_d;
    logic [1:0]           status_q, status_d;

    // Forward distance to the target. The 4-bit subtraction wraps, which
    // gives the result modulo 16.
    logic [3:0]           diff;
    assign diff = target_q - cnt_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= StIdle;
            target_q <= '0;
            dwell_q  <= '0;
            dcnt_q   <= '0;
            step_q   <= '0;
            first_q  <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            status_q <= StatReached;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            step_q   <= step_d;
            first_q  <= first_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        step_d   = step_q;
        first_d  = first_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        status_d = status_q;

        unique case (state_q)
            StIdle: begin
                // abort has no effect here, even alongside a handshake.
                if (cmd_valid) begin
                    target_d = cmd_target;
                    dwell_d  = cmd_dwell;
                    step_d   = '0;
                    first_d  = 1'b1;
                    state_d  = StEval;
                end
            end

            StEval: begin
                if (abort) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatAborted;
                end else if (cnt_q == target_q) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatReached;
                end else if (step_q == MaxSteps) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatTimeout;
                end else begin
                    // Direction is chosen once per command; a tie at 8 goes up.
                    if (first_q) begin
                        dir_d   = (diff <= 4'd8);
                        first_d = 1'b0;
                    end
                    dcnt_d  = dwell_q;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (abort) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatAborted;
                end else if (dcnt_q == '0) begin
                    state_d = StStep;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end

            StStep: begin
                if (abort) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatAborted;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = StEval;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The enable is gated by abort so that an abort in the STEP cycle
    // suppresses the step itself.
    assign cnt_en    = (state_q == StStep) && !abort;
    assign cnt_dir   = dir_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign status    = status_q;
    // Held low while reset is asserted, even though the state reads idle.
    assign cmd_ready = (state_q == StIdle) && !arst;

endmodule

// File: tb/tb_updown_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_move_ctrl
//
// Self-checking bench for updown_move_ctrl. A small counter model closes the
// cnt_en/cnt_dir -> cnt_q loop and can be frozen to provoke timeouts.
// Directed vectors come from a table; random commands are checked against a
// closed-form model of pulse times, direction, done cycle and status.
// ---------------------------------------------------------------------------
module tb_updown_move_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_target = '0;
    logic [7:0] cmd_dwell = '0;
    logic       abort = 1'b0;
    logic [3:0] cnt_q;
    logic       cnt_en;
    logic       cnt_dir;
    logic       busy;
    logic       done;
    logic [1:0] status;

    updown_move_ctrl #(.DWELL_W(8)) dut (
        .clk        (clk),
        .arst       (arst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_dwell  (cmd_dwell),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_en     (cnt_en),
        .cnt_dir    (cnt_dir),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Counter model: loadable, and freezable to force a timeout.
    logic [3:0] cnt = '0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = '0;
    logic       hold = 1'b0;
    assign cnt_q = cnt;

    always @(posedge clk) begin
        if (load_en) cnt <= load_val;
        else if (cnt_en && !hold) cnt <= cnt_dir ? cnt + 4'd1 : cnt - 4'd1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observations of the last command.
    int       obs_np;
    int       obs_pc[16];
    int       obs_pd[16];
    int       obs_done;
    int       obs_st;
    int       obs_ready;
    int       obs_busy;

    // Issue one command and record cycle numbers relative to the handshake
    // cycle (cycle 0). Returns sampling just after the done cycle's negedge.
    task automatic run_cmd(input logic [3:0] start, input logic [3:0] tgt, input int dwell,
                           input bit hold_c, input int abort_at, input bit b2b);
        if (!b2b) begin
            @(negedge clk);
            load_val = start;
            load_en  = 1'b1;
            @(negedge clk);
            load_en  = 1'b0;
        end
        hold       = hold_c;
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_dwell  = dwell[7:0];
        obs_np     = 0;
        obs_done   = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort     = (c == abort_at);
            #1;
            if (cnt_en) begin
                if (obs_np < 16) begin
                    obs_pc[obs_np] = c;
                    obs_pd[obs_np] = int'(cnt_dir);
                end
                obs_np++;
            end
            if (done) begin
                obs_done  = c;
                obs_st    = int'(status);
                obs_ready = int'(cmd_ready);
                obs_busy  = int'(busy);
                break;
            end
        end
        abort = 1'b0;
        if (obs_done < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_wait: got no done within 400 cycles, expected a done pulse");
        end
    endtask

    // Closed-form expectations from the move rules.
    int exp_np, exp_dir, exp_done, exp_st, exp_period;

    task automatic model(input logic [3:0] start, input logic [3:0] tgt, input int dwell,
                         input bit hold_c, input int abort_at);
        int diff, k, done_nom;
        diff       = (int'(tgt) - int'(start) + 16) % 16;
        exp_dir    = (diff <= 8) ? 1 : 0;
        k          = (diff == 0) ? 0 : (exp_dir == 1 ? diff : 16 - diff);
        exp_period = dwell + 3;
        exp_st     = 0;
        if (hold_c && k > 0) begin
            k      = 8;
            exp_st = 2;
        end
        done_nom = 2 + k * exp_period;
        exp_np   = k;
        exp_done = done_nom;
        if (abort_at >= 1 && abort_at <= done_nom - 1) begin
            exp_np   = (abort_at - 1) / exp_period;
            if (exp_np > k) exp_np = k;
            exp_done = abort_at + 1;
            exp_st   = 1;
        end
    endtask

    typedef struct {
        int start;
        int tgt;
        int dwell;
        int hold;
        int abort_at;
        int np;
        int dir;
        int first;
        int done_c;
        int st;
    } vec_t;

    localparam int NVec = 10;
    vec_t vecs[NVec];

    initial begin
        vecs[0] = '{3, 6, 0, 0, 0, 3, 1, 3, 11, 0};   // short up move
        vecs[1] = '{1, 14, 2, 0, 0, 3, 0, 5, 17, 0};  // down through wrap
        vecs[2] = '{0, 8, 0, 0, 0, 8, 1, 3, 26, 0};   // tie goes up
        vecs[3] = '{5, 5, 3, 0, 0, 0, 0, 0, 2, 0};    // zero move
        vecs[4] = '{0, 10, 4, 0, 10, 1, 0, 7, 11, 1}; // abort in 2nd WAIT
        vecs[5] = '{3, 6, 0, 0, 3, 0, 0, 0, 4, 1};    // abort with STEP
        vecs[6] = '{3, 6, 0, 0, 10, 3, 1, 3, 11, 1};  // abort beats final match
        vecs[7] = '{15, 0, 1, 0, 0, 1, 1, 4, 6, 0};   // up across wrap
        vecs[8] = '{0, 9, 0, 0, 0, 7, 0, 3, 23, 0};   // diff 9 goes down
        vecs[9] = '{0, 5, 0, 1, 0, 8, 1, 3, 26, 2};   // frozen counter: timeout

        // Reset state while arst is asserted.
        #2;
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_cnt_dir", int'(cnt_dir), 0);
        check("rst_status", int'(status), 0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        #1;
        check("rst_release_ready", int'(cmd_ready), 1);

        // Directed table.
        for (int i = 0; i < NVec; i++) begin
            run_cmd(vecs[i].start[3:0], vecs[i].tgt[3:0], vecs[i].dwell, vecs[i].hold != 0,
                    vecs[i].abort_at, 1'b0);
            check($sformatf("v%0d_pulses", i), obs_np, vecs[i].np);
            check($sformatf("v%0d_done_cycle", i), obs_done, vecs[i].done_c);
            check($sformatf("v%0d_status", i), obs_st, vecs[i].st);
            check($sformatf("v%0d_ready_at_done", i), obs_ready, 1);
            check($sformatf("v%0d_busy_at_done", i), obs_busy, 0);
            if (vecs[i].np > 0 && obs_np > 0) begin
                check($sformatf("v%0d_first_pulse", i), obs_pc[0], vecs[i].first);
                for (int j = 0; j < obs_np && j < 16; j++)
                    check($sformatf("v%0d_dir%0d", i, j), obs_pd[j], vecs[i].dir);
            end
        end

        // Status is held after done.
        repeat (3) @(negedge clk);
        #1;
        check("status_held", int'(status), 2);
        check("done_one_cycle", int'(done), 0);

        // Reset during WAIT of an up move.
        @(negedge clk);
        load_val = 4'd2;
        load_en  = 1'b1;
        hold     = 1'b0;
        @(negedge clk);
        load_en    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = 4'd6;
        cmd_dwell  = 8'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        arst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cnt_en", int'(cnt_en), 0);
        check("mid_rst_cnt_dir", int'(cnt_dir), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_status", int'(status), 0);
        check("mid_rst_ready", int'(cmd_ready), 0);
        @(negedge clk);
        arst = 1'b0;
        begin
            int bad_done = 0;
            int bad_ready = 0;
            for (int c = 0; c < 6; c++) begin
                #1;
                if (done) bad_done++;
                if (!cmd_ready || busy) bad_ready++;
                @(negedge clk);
            end
            check("post_rst_no_done", bad_done, 0);
            check("post_rst_ready_idle", bad_ready, 0);
        end

        // Back-to-back: second command issued in the first one's done cycle.
        run_cmd(4'd3, 4'd6, 0, 1'b0, 0, 1'b0);
        check("b2b_a_done", obs_done, 11);
        run_cmd(4'd0, 4'd4, 0, 1'b0, 0, 1'b1);
        check("b2b_b_pulses", obs_np, 2);
        check("b2b_b_done", obs_done, 8);
        check("b2b_b_status", obs_st, 0);
        check("b2b_b_dir", obs_pd[0], 0);
        check("b2b_b_counter", int'(cnt_q), 4);

        // Randomized commands against the closed-form model.
        for (int r = 0; r < 60; r++) begin
            logic [3:0] s, t;
            int d, ab;
            bit h;
            s  = 4'($urandom_range(0, 15));
            t  = 4'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 4));
            h  = ($urandom_range(0, 5) == 0);
            ab = 0;
            model(s, t, d, h, 0);
            if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(1, exp_done + 1));
            model(s, t, d, h, ab);
            run_cmd(s, t, d, h, ab, 1'b0);
            check($sformatf("r%0d_pulses", r), obs_np, exp_np);
            check($sformatf("r%0d_done_cycle", r), obs_done, exp_done);
            check($sformatf("r%0d_status", r), obs_st, exp_st);
            for (int j = 0; j < obs_np && j < exp_np && j < 16; j++) begin
                check($sformatf("r%0d_pulse%0d_cycle", r, j), obs_pc[j], (j + 1) * exp_period);
                check($sformatf("r%0d_pulse%0d_dir", r, j), obs_pd[j], exp_dir);
            end
            if (exp_st == 0 && !h)
                check($sformatf("r%0d_final_cnt", r), int'(cnt_q), int'(t));
        end

        hold = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_move_ctrl.md
# updown_move_ctrl

Command-driven move controller for a 4-bit wrapping up/down counter. It accepts "move to target value" commands over a valid/ready handshake, chooses the shortest wrap-around direction, and drives the counter's enable and direction one step at a time with a programmable dwell between steps. It reports completion, abort or timeout with a one-cycle done pulse and a status code. The block sits between the control/sequencing logic and the counter datapath; it reads the counter value back on `cnt_q`.

## Interface
- `DWELL_W`, default 8: width of the per-command dwell count.
- `clk` input 1: clock; all state updates on the rising edge.
- `arst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command; equals (state == IDLE).
- `cmd_target` input 4: target counter value; latched on handshake.
- `cmd_dwell` input DWELL_W: idle cycles inserted before each step; latched on handshake.
- `abort` input 1: cancel the active command.
- `cnt_q` input 4: current counter value, fed back from the counter.
- `cnt_en` output 1: counter step enable, one cycle per step.
- `cnt_dir` output 1: 1 = up, 0 = down.
- `busy` output 1: high when the state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `status` output 2: completion code, valid while `done` is high and held until the next `done`. 00 = reached, 01 = aborted, 10 = timeout.

## Operation
- States:
  - IDLE
  - EVAL: compare `cnt_q` with the target.
  - WAIT: dwell countdown.
  - STEP: `cnt_en` high.
- IDLE:
  - On `cmd_valid && cmd_ready`, latch `cmd_target` and `cmd_dwell`, clear the step counter, set the first-eval flag, and go to EVAL.
  - `abort` is ignored in IDLE, including in the same cycle as a handshake.
- EVAL:
  - If `cnt_q == target`: go to IDLE with status 00.
  - Else if step counter == 8: go to IDLE with status 10.
  - Else:
    - On first EVAL only, compute diff = (target − `cnt_q`) mod 16 and latch `cnt_dir` = 1 if diff ≤ 8 (a tie at 8 goes up), else 0.
    - Load the dwell counter with the latched dwell and go to WAIT.
- WAIT: if dwell counter == 0, go to STEP; else decrement it.
- STEP: `cnt_en` = 1 for exactly this cycle, increment the step counter (4-bit), then go to EVAL.
- Abort:
  - Effective in EVAL, WAIT or STEP; the next state is IDLE with status 01.
  - `cnt_en` is combinationally gated by `!abort`, so an abort during STEP produces no counter step.
- The direction is never re-evaluated mid-command, and the target is never re-latched mid-command.
- `done` is a registered pulse, high in the first IDLE cycle after any termination. `cmd_ready` is also high in that cycle, so back-to-back commands are legal.
- Reset values:
  - state = IDLE
  - `cnt_en` = 0, `cnt_dir` = 0
  - `busy` = 0, `done` = 0
  - `status` = 00
  - internal counters = 0
  - `cmd_ready` = 0 while `arst` is high and 1 after its release.
- Reset mid-command abandons the command silently; no `done` pulse is generated.

## Timing
- Handshake at cycle 0; EVAL at cycle 1.
- Each step takes D + 3 cycles: EVAL (1), WAIT (D + 1), STEP (1), where D = latched dwell.
- For a move of k steps, `done` is asserted at cycle 2 + k·(D+3). For k = 0, `done` is at cycle 2.
- The counter updates on the edge that ends STEP. EVAL samples the updated `cnt_q` the following cycle; zero extra latency is required of the counter.
- Abort sampled high in cycle n → state is IDLE and `done` is high in cycle n+1, with status 01.
- Maximum of 8 `cnt_en` pulses per command. A 9th evaluation that still mismatches yields timeout.

## Test plan
- `cnt_q` = 3, target = 6, dwell = 0:
  - 3 `cnt_en` pulses with `cnt_dir` = 1, at cycles 3, 6 and 9.
  - `done` at cycle 11, status 00.
- `cnt_q` = 1, target = 14, dwell = 2:
  - Down wrap 1→0→15→14: 3 pulses with `cnt_dir` = 0.
  - `done` at cycle 17, status 00.
- Tie and zero-move:
  - `cnt_q` = 0, target = 8, dwell = 0: 8 up pulses, `done` at cycle 26, status 00.
  - Target equal to `cnt_q`: `done` at cycle 2, no `cnt_en`.
- Abort:
  - Target 10 from 0, dwell = 4, abort asserted in the second WAIT: no further `cnt_en`, `done` next cycle, status 01.
  - Abort coincident with STEP: no `cnt_en` pulse is seen.
- Timeout: `cnt_q` held at 0, target = 5, dwell = 0 → exactly 8 up pulses, then `done` with status 10.
- Reset and back-to-back:
  - `arst` during WAIT: all outputs reach reset values immediately, no `done`, and `cmd_ready` = 1 after release.
  - Back-to-back: a second command is accepted in the `done` cycle and completes normally.
